rggen_avalon_pipelined_bridge: RTL and testbench

Registered bridge from the RgGen register bus (rggen_bus_if) to an Avalon-MM host port (rggen_avalon_if), with parametrised data width. It adds a request register slice, a registered response stage and an optional response-timeout monitor for slaves that may never respond. It sits between the generated register block's bus adapter and the Avalon interconnect, and trades latency for clean timing on both sides.

---
 rtl/rggen_rtl_pkg.sv | 20 ++
 rtl/rggen_avalon_if.sv | 26 ++
 rtl/rggen_bus_if.sv | 24 ++
 rtl/rggen_avalon_timeout_monitor.sv | 58 +++++
 rtl/rggen_avalon_pipelined_bridge.sv | 144 ++++++++++++++
 tb/tb_rggen_avalon_pipelined_bridge.sv | 274 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/rggen_rtl_pkg.sv
// Shared RgGen RTL types, plus the Avalon-MM response encoding used by the Avalon bridge.
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_READ  = 2'b10,
    RGGEN_WRITE = 2'b11
  } rggen_access;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  localparam logic [1:0] RGGEN_AVALON_OKAY        = 2'b00;
  localparam logic [1:0] RGGEN_AVALON_SLAVEERROR  = 2'b10;
  localparam logic [1:0] RGGEN_AVALON_DECODEERROR = 2'b11;

endpackage

// File: rtl/rggen_avalon_if.sv
// Avalon-MM host/agent signal bundle with read and write responses.
interface rggen_avalon_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32
);
  logic                     read;
  logic                     write;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [BUS_WIDTH/8-1:0]   byteenable;
  logic [BUS_WIDTH-1:0]     writedata;
  logic                     waitrequest;
  logic                     readdatavalid;
  logic                     writeresponsevalid;
  logic [1:0]               response;
  logic [BUS_WIDTH-1:0]     readdata;

  modport host (
    output read, write, address, byteenable, writedata,
    input  waitrequest, readdatavalid, writeresponsevalid, response, readdata
  );

  modport agent (
    input  read, write, address, byteenable, writedata,
    output waitrequest, readdatavalid, writeresponsevalid, response, readdata
  );
endinterface

// File: rtl/rggen_bus_if.sv
// RgGen register-bus request/response bundle.
interface rggen_bus_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32
);
  logic                            valid;
  rggen_rtl_pkg::rggen_access      access;
  logic [ADDRESS_WIDTH-1:0]        address;
  logic [BUS_WIDTH-1:0]            write_data;
  logic [BUS_WIDTH/8-1:0]          strobe;
  logic                            ready;
  rggen_rtl_pkg::rggen_status      status;
  logic [BUS_WIDTH-1:0]            read_data;

  modport master (
    output valid, access, address, write_data, strobe,
    input  ready, status, read_data
  );

  modport slave (
    input  valid, access, address, write_data, strobe,
    output ready, status, read_data
  );
endinterface

// File: rtl/rggen_avalon_timeout_monitor.sv
// WAIT-phase response timeout counter and saturating orphan-response counter.
// Instantiated by the bridge only when RGGEN_AVALON_BRIDGE_TIMEOUT_EN is defined.
module rggen_avalon_timeout_monitor #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic wait_i,
  input  logic response_i,
  input  logic strobe_i,
  output logic timeout_o,
  output logic orphan_pending_o,
  output logic orphan_full_o
);

  localparam int                    CountWidth = $clog2(TIMEOUT_CYCLES);
  localparam logic [CountWidth-1:0] LastCount  = CountWidth'(TIMEOUT_CYCLES - 1);

  logic [CountWidth-1:0] count_q, count_d;
  logic [1:0]            orphan_q, orphan_d;
  logic                  orphan_retire;

  // A real response in the final WAIT cycle beats the timeout.
  assign timeout_o        = wait_i && !response_i && (count_q == LastCount);
  assign orphan_retire    = strobe_i && (orphan_q != 2'd0);
  assign orphan_pending_o = orphan_q != 2'd0;
  assign orphan_full_o    = orphan_q == 2'd3;

  always_comb begin
    count_d = '0;
    if (wait_i && !response_i && !timeout_o) begin
      count_d = count_q + CountWidth'(1);
    end
  end

  // Avalon responses are in order, so the oldest abandoned access consumes each strobe.
  always_comb begin
    orphan_d = orphan_q;
    if (timeout_o && !orphan_retire) begin
      if (orphan_q != 2'd3) begin
        orphan_d = orphan_q + 2'd1;
      end
    end else if (orphan_retire && !timeout_o) begin
      orphan_d = orphan_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q  <= '0;
      orphan_q <= 2'd0;
    end else begin
      count_q  <= count_d;
      orphan_q <= orphan_d;
    end
  end

endmodule

// File: rtl/rggen_avalon_pipelined_bridge.sv
// Registered RgGen bus to Avalon-MM host bridge: request slice plus registered response stage.
// Define RGGEN_AVALON_BRIDGE_TIMEOUT_EN to add the WAIT-phase response-timeout monitor.
module rggen_avalon_pipelined_bridge
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int BUS_WIDTH      = 32,
  parameter bit READ_STROBE    = 1'b1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic          i_clk,
  input logic          i_rst_n,
  rggen_bus_if.slave   bus_if,
  rggen_avalon_if.host avalon_if
);

  typedef enum logic [1:0] {IDLE, REQUEST, WAIT, RESPOND} state_e;

  state_e                 state_q, state_d;
  logic                   read_q, read_d;
  logic                   write_q, write_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic [BUS_WIDTH-1:0]   writedata_q, writedata_d;
  logic [BUS_WIDTH/8-1:0] byteenable_q, byteenable_d;
  logic                   ready_q, ready_d;
  rggen_status            status_q, status_d;
  logic [BUS_WIDTH-1:0]   read_data_q, read_data_d;

  logic response_strobe;
  logic response_accept;
  logic capture_read;
  logic timeout;
  logic orphan_pending;
  logic orphan_full;

  assign response_strobe = avalon_if.readdatavalid | avalon_if.writeresponsevalid;
  assign response_accept = (state_q == WAIT) && response_strobe && !orphan_pending;
  assign capture_read    = bus_if.access == RGGEN_READ;

`ifdef RGGEN_AVALON_BRIDGE_TIMEOUT_EN
  rggen_avalon_timeout_monitor #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_monitor (
    .clk_i            (i_clk),
    .rst_n_i          (i_rst_n),
    .wait_i           (state_q == WAIT),
    .response_i       (response_accept),
    .strobe_i         (response_strobe),
    .timeout_o        (timeout),
    .orphan_pending_o (orphan_pending),
    .orphan_full_o    (orphan_full)
  );
`else
  assign timeout        = 1'b0;
  assign orphan_pending = 1'b0;
  assign orphan_full    = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    read_d       = read_q;
    write_d      = write_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    ready_d      = 1'b0;
    status_d     = status_q;
    read_data_d  = read_data_q;
    case (state_q)
      IDLE: begin
        if (bus_if.valid && !orphan_full) begin
          state_d      = REQUEST;
          read_d       = capture_read;
          write_d      = !capture_read;
          address_d    = ADDRESS_WIDTH'(bus_if.address);
          writedata_d  = bus_if.write_data;
          byteenable_d = (capture_read && !READ_STROBE) ? '1 : bus_if.strobe;
        end
      end
      REQUEST: begin
        if (!avalon_if.waitrequest) begin
          state_d = WAIT;
          read_d  = 1'b0;
          write_d = 1'b0;
        end
      end
      WAIT: begin
        if (response_accept) begin
          state_d     = RESPOND;
          ready_d     = 1'b1;
          status_d    = rggen_status'(avalon_if.response);
          read_data_d = avalon_if.readdata;
        end else if (timeout) begin
          state_d     = RESPOND;
          ready_d     = 1'b1;
          status_d    = RGGEN_SLAVE_ERROR;
          read_data_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      address_q    <= '0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      ready_q      <= 1'b0;
      status_q     <= RGGEN_OKAY;
      read_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      read_q       <= read_d;
      write_q      <= write_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      ready_q      <= ready_d;
      status_q     <= status_d;
      read_data_q  <= read_data_d;
    end
  end

  assign avalon_if.read       = read_q;
  assign avalon_if.write      = write_q;
  assign avalon_if.address    = address_q;
  assign avalon_if.writedata  = writedata_q;
  assign avalon_if.byteenable = byteenable_q;
  assign bus_if.ready         = ready_q;
  assign bus_if.status        = status_q;
  assign bus_if.read_data     = read_data_q;

  // A response strobe outside WAIT is only legal when it retires an abandoned access.
  a_address_width: assert property (@(posedge i_clk) $bits(avalon_if.address) == ADDRESS_WIDTH);
  a_stray_response: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(response_strobe && (state_q != WAIT) && !orphan_pending));

endmodule

// File: tb/tb_rggen_avalon_pipelined_bridge.sv
// Bench for rggen_avalon_pipelined_bridge: directed vector table, random accesses scored against a
// transaction-level model, and hand sequences for timeout/orphan, reset and READ_STROBE=0.
module tb_rggen_avalon_pipelined_bridge;
  import rggen_rtl_pkg::*;

  localparam int AW      = 16;
  localparam int BW      = 32;
  localparam int BUS_AW  = 20;
  localparam int TIMEOUT = 8;
  localparam int BUDGET  = 40;
`ifdef RGGEN_AVALON_BRIDGE_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  typedef struct {
    bit          isRead;
    logic [19:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waitCycles;
    int          respDelay;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic [15:0] expAddr;
    logic [3:0]  expBe;
    int          expReady;
    logic [1:0]  expStatus;
    logic [31:0] expData;
  } vec_t;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clock = ~clock;

  rggen_bus_if    #(.ADDRESS_WIDTH(BUS_AW), .BUS_WIDTH(BW)) bus ();
  rggen_avalon_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW))     av ();
  rggen_bus_if    #(.ADDRESS_WIDTH(BUS_AW), .BUS_WIDTH(BW)) bus2 ();
  rggen_avalon_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW))     av2 ();

  rggen_avalon_pipelined_bridge #(
    .ADDRESS_WIDTH (AW),
    .BUS_WIDTH     (BW),
    .READ_STROBE   (1'b1),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .i_clk     (clock),
    .i_rst_n   (rst_n),
    .bus_if    (bus),
    .avalon_if (av)
  );

  rggen_avalon_pipelined_bridge #(
    .ADDRESS_WIDTH (AW),
    .BUS_WIDTH     (BW),
    .READ_STROBE   (1'b0),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut2 (
    .i_clk     (clock),
    .i_rst_n   (rst_n),
    .bus_if    (bus2),
    .avalon_if (av2)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Transaction-level expectations: the request occupies waitCycles+1 cycles starting one cycle after
  // valid, WAIT begins right after, and ready follows the response (or the timeout) by one cycle.
  function automatic vec_t modelAccess(input vec_t v);
    vec_t m;
    int   firstWait;
    m         = v;
    firstWait = 2 + v.waitCycles;
    m.expAddr = v.addr[AW-1:0];
    m.expBe   = v.strb;
    if (v.respDelay >= 0 && (!TIMEOUT_ON || v.respDelay < TIMEOUT)) begin
      m.expReady  = firstWait + v.respDelay + 1;
      m.expStatus = v.resp;
      m.expData   = v.rdata;
    end else begin
      m.expReady  = firstWait + TIMEOUT;
      m.expStatus = RGGEN_AVALON_SLAVEERROR;
      m.expData   = '0;
    end
    return m;
  endfunction

  // Acts as both bus master and Avalon agent for one access; cycle 0 is the cycle valid is raised.
  task automatic applyStimulus(input string tag, input vec_t v);
    int          readyAt;
    int          firstReq;
    int          reqCycles;
    int          fieldErr;
    int          respCycle;
    logic [1:0]  gotStatus;
    logic [31:0] gotData;
    logic        readyAfter;
    readyAt   = -1;
    firstReq  = -1;
    reqCycles = 0;
    fieldErr  = 0;
    gotStatus = 2'b00;
    gotData   = '0;
    respCycle = (v.respDelay < 0) ? -1 : 2 + v.waitCycles + v.respDelay;
    @(posedge clock); #1;
    bus.valid      = 1'b1;
    bus.access     = v.isRead ? RGGEN_READ : RGGEN_WRITE;
    bus.address    = v.addr;
    bus.write_data = v.wdata;
    bus.strobe     = v.strb;
    for (int c = 0; c < BUDGET && readyAt < 0; c++) begin
      if (c > 0) begin
        @(posedge clock); #1;
      end
      av.waitrequest        = (c <= v.waitCycles);
      av.readdatavalid      = v.isRead && (c == respCycle);
      av.writeresponsevalid = !v.isRead && (c == respCycle);
      av.response           = v.resp;
      av.readdata           = v.rdata;
      @(negedge clock);
      if (av.read || av.write) begin
        reqCycles++;
        if (firstReq < 0) firstReq = c;
        if (av.read !== v.isRead || av.write !== !v.isRead || av.address !== v.expAddr ||
            av.byteenable !== v.expBe || av.writedata !== v.wdata) fieldErr++;
      end
      if (bus.ready) begin
        readyAt   = c;
        gotStatus = bus.status;
        gotData   = bus.read_data;
      end
    end
    @(posedge clock); #1;
    bus.valid             = 1'b0;
    av.readdatavalid      = 1'b0;
    av.writeresponsevalid = 1'b0;
    av.waitrequest        = 1'b0;
    @(negedge clock);
    readyAfter = bus.ready;
    checkOutput({tag, ".first_request_cycle"}, 64'(firstReq), 64'(1));
    checkOutput({tag, ".request_cycles"}, 64'(reqCycles), 64'(v.waitCycles + 1));
    checkOutput({tag, ".request_field_errors"}, 64'(fieldErr), 64'(0));
    checkOutput({tag, ".ready_cycle"}, 64'(readyAt), 64'(v.expReady));
    checkOutput({tag, ".status"}, 64'(gotStatus), 64'(v.expStatus));
    checkOutput({tag, ".read_data"}, 64'(gotData), 64'(v.expData));
    checkOutput({tag, ".ready_one_cycle"}, 64'(readyAfter), 64'(0));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: summary not reached, got %0d compared, expected completion", compared);
    $fatal(1);
  end

  initial begin
    vec_t vectors [4];
    vec_t v;

    vectors[0] = '{1'b1, 20'h00010, 32'h00000000, 4'hF, 0, 0, 32'hDEADBEEF, 2'b00,
                   16'h0010, 4'hF, 3, 2'b00, 32'hDEADBEEF};
    vectors[1] = '{1'b0, 20'h00020, 32'h12345678, 4'b0011, 4, 0, 32'h00000000, 2'b10,
                   16'h0020, 4'b0011, 7, 2'b10, 32'h00000000};
    vectors[2] = '{1'b1, 20'hA0044, 32'h00000000, 4'b0100, 2, 3, 32'hA5A50F0F, 2'b11,
                   16'h0044, 4'b0100, 8, 2'b11, 32'hA5A50F0F};
    vectors[3] = '{1'b0, 20'h0FFFC, 32'hCAFEF00D, 4'b1100, 0, 1, 32'h11112222, 2'b00,
                   16'hFFFC, 4'b1100, 4, 2'b00, 32'h11112222};

    bus.valid = 1'b0; bus.access = RGGEN_READ; bus.address = '0; bus.write_data = '0; bus.strobe = '0;
    av.waitrequest = 1'b0; av.readdatavalid = 1'b0; av.writeresponsevalid = 1'b0;
    av.response = 2'b00; av.readdata = '0;
    bus2.valid = 1'b0; bus2.access = RGGEN_READ; bus2.address = '0; bus2.write_data = '0; bus2.strobe = '0;
    av2.waitrequest = 1'b0; av2.readdatavalid = 1'b0; av2.writeresponsevalid = 1'b0;
    av2.response = 2'b00; av2.readdata = '0;

    #12;
    checkOutput("reset.avalon_ctrl", 64'({av.read, av.write, av.address, av.byteenable}), 64'(0));
    checkOutput("reset.writedata", 64'(av.writedata), 64'(0));
    checkOutput("reset.ready_status", 64'({bus.ready, bus.status}), 64'({1'b0, RGGEN_OKAY}));
    checkOutput("reset.read_data", 64'(bus.read_data), 64'(0));
    @(negedge clock);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      applyStimulus($sformatf("vec%0d", i), vectors[i]);
    end

`ifdef RGGEN_AVALON_BRIDGE_TIMEOUT_EN
    v = '{1'b1, 20'h00100, 32'h0, 4'hF, 0, -1, 32'h77777777, 2'b00, 16'h0100, 4'hF, 10, 2'b10, 32'h0};
    applyStimulus("timeout", v);
    @(posedge clock); #1;
    av.readdatavalid = 1'b1;
    av.readdata      = 32'hBAD0BAD0;
    @(negedge clock);
    checkOutput("late_response.ready", 64'(bus.ready), 64'(0));
    @(posedge clock); #1;
    av.readdatavalid = 1'b0;
    v = '{1'b1, 20'h00200, 32'h0, 4'hF, 0, 0, 32'h600D600D, 2'b00, 16'h0200, 4'hF, 3, 2'b00, 32'h600D600D};
    applyStimulus("after_orphan", v);
`endif

    for (int i = 0; i < 20; i++) begin
      v            = vectors[0];
      v.isRead     = 1'($urandom_range(0, 1));
      v.addr       = 20'($urandom());
      v.wdata      = $urandom();
      v.strb       = 4'($urandom());
      v.waitCycles = $urandom_range(0, 4);
      v.respDelay  = $urandom_range(0, 4);
      v.rdata      = $urandom();
      case ($urandom_range(0, 2))
        0:       v.resp = RGGEN_AVALON_OKAY;
        1:       v.resp = RGGEN_AVALON_SLAVEERROR;
        default: v.resp = RGGEN_AVALON_DECODEERROR;
      endcase
      applyStimulus($sformatf("rand%0d", i), modelAccess(v));
    end

    // Reset while the bridge sits in WAIT with no response coming.
    @(posedge clock); #1;
    bus.valid      = 1'b1;
    bus.access     = RGGEN_READ;
    bus.address    = 20'h00ABC;
    bus.write_data = 32'h5555AAAA;
    bus.strobe     = 4'hF;
    av.waitrequest = 1'b0;
    repeat (3) @(posedge clock);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset.avalon_ctrl", 64'({av.read, av.write, av.address, av.byteenable}), 64'(0));
    checkOutput("midreset.writedata", 64'(av.writedata), 64'(0));
    checkOutput("midreset.ready_status", 64'({bus.ready, bus.status}), 64'({1'b0, RGGEN_OKAY}));
    checkOutput("midreset.read_data", 64'(bus.read_data), 64'(0));
    bus.valid = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    v = '{1'b1, 20'h00030, 32'h0, 4'b1010, 1, 1, 32'h0BADCAFE, 2'b00, 16'h0030, 4'b1010, 5, 2'b00, 32'h0BADCAFE};
    applyStimulus("post_reset", v);

    // READ_STROBE=0 instance: a read must drive all-ones byteenable.
    @(posedge clock); #1;
    bus2.valid   = 1'b1;
    bus2.access  = RGGEN_READ;
    bus2.address = 20'h00008;
    bus2.strobe  = 4'b0001;
    @(posedge clock); #1;
    @(negedge clock);
    checkOutput("rs0.read", 64'(av2.read), 64'(1));
    checkOutput("rs0.byteenable", 64'(av2.byteenable), 64'(4'hF));
    @(posedge clock); #1;
    av2.readdatavalid = 1'b1;
    av2.readdata      = 32'h000000AB;
    @(posedge clock); #1;
    av2.readdatavalid = 1'b0;
    @(negedge clock);
    checkOutput("rs0.ready_data", 64'({bus2.ready, bus2.read_data}), 64'({1'b1, 32'h000000AB}));
    @(posedge clock); #1;
    bus2.valid = 1'b0;
    repeat (2) @(posedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
